instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the single-issue RISC-V pipeline. Owns the program counter and drives the word address into `instruction_memory`, whose read is combinational. It captures the returned word together with its PC into the IF/ID pipeline register for decode. It handles load-use stalls, branch/jump redirects from EX and pipeline flushes, and halts on fetch faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
- `IMEM_WORDS`, default 1024: instruction memory depth, used for the range check.

Ports. One clock; reset is asynchronous and active-high (`clk`, `rst`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `stall`  in  1  hold PC and IF/ID (load-use hazard from ID).
- `flush`  in  1  replace the IF/ID contents with a bubble.
- `redirect_valid`  in  1  EX-resolved taken branch or jump.
- `redirect_pc`  in  32  redirect target.
- `pc`  out  32  current fetch PC, wired to `instruction_memory.pc`.
- `imem_rdata`  in  32  `instruction_memory.instruction`, same cycle as `pc`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_pc`  out  32  PC of the IF/ID instruction.
- `ifid_pc_plus4`  out  32  `ifid_pc` + 4, used as the link value.
- `ifid_instr`  out  32  instruction word; `NOP_INSTR` when not valid.
- `fetch_fault`  out  1  sticky; the stage is in HALT.
- `fetch_count`  out  32  number of instructions written into IF/ID with valid=1.

## Operation
State machine:
- RUN: normal fetch.
- HALT: entered on a fault. Leaving HALT requires `rst`.

RUN, evaluated each edge in strict priority order:
1. **Redirect.** If `redirect_valid` and `redirect_pc[1:0]` = 0: `pc` <= `redirect_pc`; IF/ID <= bubble. `stall` is ignored because the branch is older than the stalled instruction.
2. **Misaligned redirect.** If `redirect_valid` and `redirect_pc[1:0]` != 0: go to HALT; `pc` holds; IF/ID <= bubble.
3. **Flush.** If `flush`: `pc` <= `pc` + 4; IF/ID <= bubble.
4. **Stall.** If `stall`: `pc` and IF/ID both hold.
5. **Out of range.** If `pc[31:2]` >= `IMEM_WORDS`: go to HALT; IF/ID <= bubble.
6. **Normal.** IF/ID <= {valid=1, `pc`, `pc`+4, `imem_rdata`}; `pc` <= `pc` + 4; `fetch_count` increments.

A bubble is defined as: valid=0, `ifid_instr` = `NOP_INSTR`, `ifid_pc` and `ifid_pc_plus4` hold their previous values.

HALT:
- `pc` and `fetch_count` freeze.
- IF/ID is a bubble every cycle.
- `fetch_fault` = 1.
- All inputs except `rst` are ignored.

Arithmetic:
- All PC arithmetic is 32-bit and wraps modulo 2^32.
- `fetch_count` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values (asynchronous, take effect immediately):
  - `pc` = `RESET_PC`
  - `ifid_valid` = 0, `ifid_instr` = `NOP_INSTR`, `ifid_pc` = 0, `ifid_pc_plus4` = 0
  - `fetch_fault` = 0, `fetch_count` = 0, state = RUN
- Reset released mid-operation restarts fetch at `RESET_PC` on the first edge after deassertion.
- Fetch latency is 1 cycle: the word at `pc` in cycle N appears in IF/ID in cycle N+1.
- Redirect penalty:
  - Redirect asserted in cycle N gives `pc` = target and `ifid_valid` = 0 in N+1.
  - The target instruction is in IF/ID in N+2.
- Stall holds for as many cycles as it is asserted; fetch resumes on the first edge with `stall` = 0.
- All outputs are registered except `pc`, which is the register itself. There is no combinational path from any input to any output.

## Structure
- Shared package `fetch_pkg` holds:
  - `NOP_INSTR` and `RESET_PC` constants.
  - The `fetch_state_t` enum {RUN, HALT}.
  - An `ifid_t` struct {valid, pc, pc_plus4, instr}, reused by decode.
- No sub-module is needed. The PC register, the IF/ID register and the fault FSM live in one module; the misalignment and range checks are inline comparators.

## Test plan
Each scenario runs against the current `instruction_memory` image.
1. **Reset then run.** Release `rst`, run 3 edges -> IF/ID shows in order:
   - pc 0x0, instr 10000413
   - pc 0x4, instr 00000293
   - pc 0x8, instr 00400313
   - `fetch_count` = 3.
2. **Stall.** Assert `stall` for 2 cycles at pc 0x10 -> `pc` and IF/ID unchanged for 2 cycles; next edge IF/ID = {0x10, 00000393}.
3. **Redirect.** Redirect to 0x58 -> next cycle `pc` = 0x58 and `ifid_valid` = 0; following cycle IF/ID = {0x58, 00128293}. Repeat with `stall` = 1 in the same cycle -> identical result.
4. **Flush.** `flush` at pc 0x20 -> `ifid_valid` = 0 and `ifid_instr` = 00000013; `pc` = 0x24; `fetch_count` does not increment.
5. **Faults.**
   - Redirect to 0x5A -> `fetch_fault` = 1, `pc` holds, `ifid_valid` stays 0 for 10+ cycles with `stall`/`redirect_valid` toggled.
   - Redirect to 0x1000 -> HALT on the next edge.
6. **Reset from HALT.** Assert `rst` mid-cycle while in HALT -> all outputs at reset values immediately; fetch of 10000413 resumes after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the IF/ID struct is also consumed by decode.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register from a combinational imem,
// and halts on misaligned redirects or out-of-range fetches until reset.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  ifid_t        ifid_q, ifid_d, bubble;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         misaligned, out_of_range;

  assign misaligned   = redirect_pc[1:0] != 2'b00;
  assign out_of_range = {2'b00, pc_q[31:2]} >= IMEM_WORDS;

  // A bubble keeps the previous PC fields so decode never sees stale-but-changing link values.
  assign bubble = '{valid: 1'b0, pc: ifid_q.pc, pc_plus4: ifid_q.pc_plus4, instr: NOP_INSTR};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          state_d = misaligned ? StHalt : StRun;
        end else if (!flush && !stall && out_of_range) begin
          state_d = StHalt;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    count_d = count_q;
    unique case (state_q)
      StRun: begin
        if (redirect_valid && !misaligned) begin
          pc_d   = redirect_pc;
          ifid_d = bubble;
        end else if (redirect_valid) begin
          ifid_d = bubble;
        end else if (flush) begin
          pc_d   = pc_q + 32'd4;
          ifid_d = bubble;
        end else if (stall) begin
          ifid_d = ifid_q;
        end else if (out_of_range) begin
          ifid_d = bubble;
        end else begin
          ifid_d  = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_q + 32'd4, instr: imem_rdata};
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
        end
      end
      default: ifid_d = bubble;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, pc: 32'd0, pc_plus4: 32'd0, instr: NOP_INSTR};
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      count_q <= count_d;
    end
  end

  assign pc            = pc_q;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_instr    = ifid_q.instr;
  assign fetch_fault   = state_q == StHalt;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a small instruction-memory image.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] imem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[pc[11:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
    check({tag, " valid"}, {31'd0, ifid_valid}, 32'd1);
    check({tag, " pc"}, ifid_pc, epc);
    check({tag, " pc+4"}, ifid_pc_plus4, epc + 32'd4);
    check({tag, " instr"}, ifid_instr, einstr);
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] epc);
    check({tag, " valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, " instr"}, ifid_instr, 32'h0000_0013);
    check({tag, " held pc"}, ifid_pc, epc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'hA000_0000 | i;
    imem[0]     = 32'h1000_0413;
    imem[1]     = 32'h0000_0293;
    imem[2]     = 32'h0040_0313;
    imem[4]     = 32'h0000_0393;
    imem[22]    = 32'h0012_8293;
    imem[1023]  = 32'hDEAD_BEEF;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst pc", pc, 32'h0);
    check("rst valid", {31'd0, ifid_valid}, 32'd0);
    check("rst instr", ifid_instr, 32'h0000_0013);
    check("rst ifid_pc", ifid_pc, 32'h0);
    check("rst pc+4", ifid_pc_plus4, 32'h0);
    check("rst fault", {31'd0, fetch_fault}, 32'd0);
    check("rst count", fetch_count, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    step(); check_ifid("run0", 32'h0, 32'h1000_0413); check("run0 pc", pc, 32'h4);
    step(); check_ifid("run1", 32'h4, 32'h0000_0293);
    step(); check_ifid("run2", 32'h8, 32'h0040_0313);
    check("run count", fetch_count, 32'd3);
    step(); check("pre-stall pc", pc, 32'h10);

    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall pc", pc, 32'h10);
      check("stall ifid_pc", ifid_pc, 32'hC);
      check("stall count", fetch_count, 32'd4);
    end
    stall = 1'b0;
    step(); check_ifid("resume", 32'h10, 32'h0000_0393); check("resume count", fetch_count, 32'd5);

    step(); step(); step();
    check("pre-flush pc", pc, 32'h20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_bubble("flush", 32'h1C);
    check("flush pc", pc, 32'h24);
    check("flush count", fetch_count, 32'd8);

    redirect_valid = 1'b1; redirect_pc = 32'h58;
    step();
    redirect_valid = 1'b0;
    check("redir pc", pc, 32'h58);
    check_bubble("redir", 32'h1C);
    step(); check_ifid("redir tgt", 32'h58, 32'h0012_8293); check("redir count", fetch_count, 32'd9);

    redirect_valid = 1'b1; redirect_pc = 32'h58; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("redir+stall pc", pc, 32'h58);
    check("redir+stall valid", {31'd0, ifid_valid}, 32'd0);
    step(); check_ifid("redir+stall tgt", 32'h58, 32'h0012_8293);

    redirect_valid = 1'b1; redirect_pc = 32'h5A;
    step();
    check("misal fault", {31'd0, fetch_fault}, 32'd1);
    check("misal pc", pc, 32'h5C);
    check("misal valid", {31'd0, ifid_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; redirect_valid = i[1]; flush = i[2]; redirect_pc = 32'h40;
      step();
      check("halt pc", pc, 32'h5C);
      check("halt valid", {31'd0, ifid_valid}, 32'd0);
      check("halt fault", {31'd0, fetch_fault}, 32'd1);
      check("halt count", fetch_count, 32'd10);
    end

    #2 rst = 1'b1;
    #1;
    check("rst2 pc", pc, 32'h0);
    check("rst2 fault", {31'd0, fetch_fault}, 32'd0);
    check("rst2 count", fetch_count, 32'd0);
    check("rst2 ifid_pc", ifid_pc, 32'h0);
    check("rst2 instr", ifid_instr, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    step(); check_ifid("rst2 run", 32'h0, 32'h1000_0413); check("rst2 cnt1", fetch_count, 32'd1);

    // Last in-range word fetches; the next word is out of range.
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    check("edge pc", pc, 32'hFFC);
    step(); check_ifid("last word", 32'hFFC, 32'hDEAD_BEEF);
    check("last pc", pc, 32'h1000);
    check("last fault", {31'd0, fetch_fault}, 32'd0);
    step();
    check("oor fault", {31'd0, fetch_fault}, 32'd1);
    check("oor pc", pc, 32'h1000);
    check("oor valid", {31'd0, ifid_valid}, 32'd0);
    check("oor count", fetch_count, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
